// File: rtl/bpu_btb.sv
// Fetch-stage branch predictor: a direct-mapped BTB with one 2-bit saturating
// direction counter per entry. Lookups are registered, so the prediction for
// a request comes out one cycle later. The block also counts prediction
// successes and failures reported back by the branch unit.
module bpu_btb #(
  parameter int XLEN       = 32,
  parameter int NB_ENTRIES = 16,
  parameter int IDX_W      = $clog2(NB_ENTRIES),
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             if_v_i,
  input  logic [XLEN-1:0]  if_pc_i,
  output logic             pred_v_o,
  output logic             pred_is_taken_o,
  output logic [XLEN-1:0]  pred_pc_o,
  input  logic             bu_en_i,
  input  logic             branch_v_i,
  input  logic [XLEN-1:0]  upd_pc_i,
  input  logic [XLEN-1:0]  upd_target_i,
  input  logic             pred_feedback_i,
  input  logic             pred_success_i,
  input  logic             pred_failed_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] success_cnt_o,
  output logic [CNT_W-1:0] failed_cnt_o
);

  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [NB_ENTRIES-1:0] r_valid;
  logic [1:0]            r_ctr    [NB_ENTRIES];
  logic [TAG_W-1:0]      r_tag    [NB_ENTRIES];
  logic [XLEN-1:0]       r_target [NB_ENTRIES];

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic [1:0]       w_ctr_next;
  logic             w_unused_pc_lsb;

  // Instructions are word aligned; the byte offset plays no part in the lookup.
  assign w_unused_pc_lsb = ^{if_pc_i[1:0], upd_pc_i[1:0]};

  assign w_lk_idx = if_pc_i[IDX_W+1:2];
  assign w_lk_tag = if_pc_i[XLEN-1:IDX_W+2];
  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

  assign w_up_idx = upd_pc_i[IDX_W+1:2];
  assign w_up_tag = upd_pc_i[XLEN-1:IDX_W+2];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  // Saturating step of the direction counter of the entry being updated.
  always_comb begin
    w_ctr_next = r_ctr[w_up_idx];
    if (branch_v_i) begin
      if (r_ctr[w_up_idx] != 2'b11) w_ctr_next = r_ctr[w_up_idx] + 2'b01;
    end else begin
      if (r_ctr[w_up_idx] != 2'b00) w_ctr_next = r_ctr[w_up_idx] - 2'b01;
    end
  end

  // Registered lookup; reads the arrays before any same-edge update (no bypass).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pred_v_o        <= 1'b0;
      pred_is_taken_o <= 1'b0;
      pred_pc_o       <= '0;
    end else if (if_v_i) begin
      pred_v_o        <= w_lk_hit;
      pred_is_taken_o <= w_lk_hit & r_ctr[w_lk_idx][1];
      pred_pc_o       <= w_lk_hit ? r_target[w_lk_idx] : '0;
    end else begin
      pred_v_o        <= 1'b0;
      pred_is_taken_o <= 1'b0;
      pred_pc_o       <= '0;
    end
  end

  // Valid bits and counters: flush wins over update; allocation only on a taken miss.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      for (int i = 0; i < NB_ENTRIES; i++) r_ctr[i] <= 2'b00;
    end else if (flush_i) begin
      r_valid <= '0;
    end else if (bu_en_i) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx] <= w_ctr_next;
      end else if (branch_v_i) begin
        r_valid[w_up_idx] <= 1'b1;
        r_ctr[w_up_idx]   <= 2'b10;
      end
    end
  end

  // Tag and target payload; a taken update either allocates or refreshes the target.
  always_ff @(posedge clk) begin
    if (!flush_i && bu_en_i && branch_v_i) begin
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= upd_target_i;
    end
  end

  // Prediction outcome counters, wrapping naturally at their width.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      success_cnt_o <= '0;
      failed_cnt_o  <= '0;
    end else begin
      if (pred_feedback_i && pred_success_i) success_cnt_o <= success_cnt_o + 1'b1;
      if (pred_feedback_i && pred_failed_i)  failed_cnt_o  <= failed_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_bpu_btb.sv
// Bench for bpu_btb: a directed vector table for the documented scenarios,
// hand sequences for the perf counters and mid-run reset, and a randomized
// run compared against a behavioural model of the BTB.
module tb_bpu_btb;

  localparam int XLEN  = 32;
  localparam int NBE   = 16;
  localparam int CNT_W = 8;

  logic             clk;
  logic             reset_n;
  logic             if_v_i;
  logic [XLEN-1:0]  if_pc_i;
  logic             pred_v_o;
  logic             pred_is_taken_o;
  logic [XLEN-1:0]  pred_pc_o;
  logic             bu_en_i;
  logic             branch_v_i;
  logic [XLEN-1:0]  upd_pc_i;
  logic [XLEN-1:0]  upd_target_i;
  logic             pred_feedback_i;
  logic             pred_success_i;
  logic             pred_failed_i;
  logic             flush_i;
  logic [CNT_W-1:0] success_cnt_o;
  logic [CNT_W-1:0] failed_cnt_o;

  bpu_btb #(.XLEN(XLEN), .NB_ENTRIES(NBE), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .if_v_i          (if_v_i),
    .if_pc_i         (if_pc_i),
    .pred_v_o        (pred_v_o),
    .pred_is_taken_o (pred_is_taken_o),
    .pred_pc_o       (pred_pc_o),
    .bu_en_i         (bu_en_i),
    .branch_v_i      (branch_v_i),
    .upd_pc_i        (upd_pc_i),
    .upd_target_i    (upd_target_i),
    .pred_feedback_i (pred_feedback_i),
    .pred_success_i  (pred_success_i),
    .pred_failed_i   (pred_failed_i),
    .flush_i         (flush_i),
    .success_cnt_o   (success_cnt_o),
    .failed_cnt_o    (failed_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Success and failure reported together is not a legal input.
  always @(posedge clk) begin
    assert (!(pred_success_i && pred_failed_i));
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Behavioural model: per-entry valid/tag/target and an integer confidence 0..3.
  bit          m_valid  [NBE];
  logic [31:0] m_tag    [NBE];
  logic [31:0] m_target [NBE];
  int          m_ctr    [NBE];
  int          m_succ, m_fail;
  logic        e_v, e_t;
  logic [31:0] e_pc;

  task automatic model_reset();
    for (int i = 0; i < NBE; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 0;
    end
    m_succ = 0;
    m_fail = 0;
    e_v = 0; e_t = 0; e_pc = 0;
  endtask

  task automatic model_edge();
    int  li, ui;
    bit  hit;
    if (if_v_i) begin
      li   = int'((if_pc_i / 4) % NBE);
      hit  = m_valid[li] && (m_tag[li] == if_pc_i / (4 * NBE));
      e_v  = hit;
      e_t  = hit && (m_ctr[li] >= 2);
      e_pc = hit ? m_target[li] : 32'h0;
    end else begin
      e_v = 0; e_t = 0; e_pc = 0;
    end
    if (flush_i) begin
      for (int i = 0; i < NBE; i++) m_valid[i] = 0;
    end else if (bu_en_i) begin
      ui  = int'((upd_pc_i / 4) % NBE);
      hit = m_valid[ui] && (m_tag[ui] == upd_pc_i / (4 * NBE));
      if (hit) begin
        if (branch_v_i) begin
          m_ctr[ui]    = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
          m_target[ui] = upd_target_i;
        end else begin
          m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
        end
      end else if (branch_v_i) begin
        m_valid[ui]  = 1;
        m_tag[ui]    = upd_pc_i / (4 * NBE);
        m_target[ui] = upd_target_i;
        m_ctr[ui]    = 2;
      end
    end
    if (pred_feedback_i && pred_success_i) m_succ = (m_succ + 1) % (1 << CNT_W);
    if (pred_feedback_i && pred_failed_i)  m_fail = (m_fail + 1) % (1 << CNT_W);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    if_v_i = 0; if_pc_i = 0; bu_en_i = 0; branch_v_i = 0;
    upd_pc_i = 0; upd_target_i = 0; pred_feedback_i = 0;
    pred_success_i = 0; pred_failed_i = 0; flush_i = 0;
  endtask

  function automatic logic [31:0] rpc();
    return 32'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
  endfunction

  typedef struct {
    logic        iv;
    logic [31:0] if_pc;
    logic        bu;
    logic        bv;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic        fl;
    logic        ev;
    logic        et;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[25];

  initial begin
    // iv  if_pc     bu  bv  upd_pc    upd_tgt   fl  ev  et  exp_pc
    vecs[0]  = '{1, 32'h100, 0, 0, 32'h000, 32'h000, 0, 0, 0, 32'h000};
    vecs[1]  = '{0, 32'h000, 1, 1, 32'h100, 32'h200, 0, 0, 0, 32'h000};
    vecs[2]  = '{1, 32'h100, 1, 1, 32'h100, 32'h200, 0, 1, 1, 32'h200};
    vecs[3]  = '{1, 32'h100, 1, 1, 32'h100, 32'h200, 0, 1, 1, 32'h200};
    vecs[4]  = '{1, 32'h100, 1, 0, 32'h100, 32'h000, 0, 1, 1, 32'h200};
    vecs[5]  = '{1, 32'h100, 0, 0, 32'h000, 32'h000, 0, 1, 1, 32'h200};
    vecs[6]  = '{1, 32'h100, 1, 0, 32'h100, 32'h000, 0, 1, 1, 32'h200};
    vecs[7]  = '{1, 32'h100, 1, 0, 32'h100, 32'h000, 0, 1, 0, 32'h200};
    vecs[8]  = '{1, 32'h100, 1, 0, 32'h100, 32'h000, 0, 1, 0, 32'h200};
    vecs[9]  = '{1, 32'h100, 0, 0, 32'h000, 32'h000, 0, 1, 0, 32'h200};
    vecs[10] = '{1, 32'h100, 1, 1, 32'h100, 32'h204, 0, 1, 0, 32'h200};
    vecs[11] = '{1, 32'h100, 0, 0, 32'h000, 32'h000, 0, 1, 0, 32'h204};
    vecs[12] = '{1, 32'h100, 1, 1, 32'h140, 32'h500, 0, 1, 0, 32'h204};
    vecs[13] = '{1, 32'h100, 0, 0, 32'h000, 32'h000, 0, 0, 0, 32'h000};
    vecs[14] = '{1, 32'h140, 0, 0, 32'h000, 32'h000, 0, 1, 1, 32'h500};
    vecs[15] = '{1, 32'h143, 0, 0, 32'h000, 32'h000, 0, 1, 1, 32'h500};
    vecs[16] = '{1, 32'h144, 0, 0, 32'h000, 32'h000, 0, 0, 0, 32'h000};
    vecs[17] = '{1, 32'h140, 1, 0, 32'h180, 32'h000, 0, 1, 1, 32'h500};
    vecs[18] = '{1, 32'h140, 0, 0, 32'h000, 32'h000, 0, 1, 1, 32'h500};
    vecs[19] = '{1, 32'h140, 1, 1, 32'h300, 32'h600, 1, 1, 1, 32'h500};
    vecs[20] = '{1, 32'h140, 0, 0, 32'h000, 32'h000, 0, 0, 0, 32'h000};
    vecs[21] = '{1, 32'h300, 0, 0, 32'h000, 32'h000, 0, 0, 0, 32'h000};
    vecs[22] = '{1, 32'h300, 1, 1, 32'h300, 32'h600, 0, 0, 0, 32'h000};
    vecs[23] = '{1, 32'h300, 0, 0, 32'h000, 32'h000, 0, 1, 1, 32'h600};
    vecs[24] = '{0, 32'h300, 0, 0, 32'h000, 32'h000, 0, 0, 0, 32'h000};

    idle_inputs();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_pred_v", 32'(pred_v_o), 0);
    chk("rst_pred_pc", pred_pc_o, 0);
    chk("rst_succ", 32'(success_cnt_o), 0);
    chk("rst_fail", 32'(failed_cnt_o), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 25; i++) begin
      if_v_i = vecs[i].iv; if_pc_i = vecs[i].if_pc;
      bu_en_i = vecs[i].bu; branch_v_i = vecs[i].bv;
      upd_pc_i = vecs[i].upc; upd_target_i = vecs[i].utgt;
      flush_i = vecs[i].fl;
      tick();
      chk($sformatf("vec%0d_pred_v", i), 32'(pred_v_o), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_taken", i), 32'(pred_is_taken_o), 32'(vecs[i].et));
      chk($sformatf("vec%0d_pred_pc", i), pred_pc_o, vecs[i].epc);
    end
    idle_inputs();
    chk("table_succ", 32'(success_cnt_o), 0);
    chk("table_fail", 32'(failed_cnt_o), 0);

    // Perf counters.
    pred_feedback_i = 1; pred_success_i = 1;
    repeat (5) tick();
    pred_success_i = 0; pred_failed_i = 1;
    repeat (2) tick();
    chk("perf_succ5", 32'(success_cnt_o), 5);
    chk("perf_fail2", 32'(failed_cnt_o), 2);
    pred_feedback_i = 0; pred_failed_i = 0; pred_success_i = 1;
    tick();
    pred_success_i = 0; pred_failed_i = 1;
    tick();
    chk("perf_nofb_succ", 32'(success_cnt_o), 5);
    chk("perf_nofb_fail", 32'(failed_cnt_o), 2);
    pred_feedback_i = 1;
    repeat (253) tick();
    chk("perf_fail_max", 32'(failed_cnt_o), 255);
    tick();
    chk("perf_fail_wrap", 32'(failed_cnt_o), 0);
    chk("perf_succ_hold", 32'(success_cnt_o), 5);
    idle_inputs();

    // Randomized run against the model.
    for (int c = 0; c < 2000; c++) begin
      int sel;
      if_v_i       = ($urandom_range(0, 3) != 0);
      if_pc_i      = rpc();
      bu_en_i      = $urandom_range(0, 1);
      branch_v_i   = $urandom_range(0, 1);
      upd_pc_i     = rpc();
      upd_target_i = $urandom;
      flush_i      = ($urandom_range(0, 63) == 0);
      pred_feedback_i = $urandom_range(0, 1);
      sel = $urandom_range(0, 2);
      pred_success_i = (sel == 0);
      pred_failed_i  = (sel == 1);
      tick();
      chk("rnd_pred_v", 32'(pred_v_o), 32'(e_v));
      chk("rnd_taken", 32'(pred_is_taken_o), 32'(e_t));
      chk("rnd_pred_pc", pred_pc_o, e_pc);
      chk("rnd_succ", 32'(success_cnt_o), 32'(m_succ));
      chk("rnd_fail", 32'(failed_cnt_o), 32'(m_fail));
    end
    idle_inputs();

    // Reset asserted mid-operation.
    bu_en_i = 1; branch_v_i = 1; upd_pc_i = 32'h100; upd_target_i = 32'h700;
    tick();
    idle_inputs();
    if_v_i = 1; if_pc_i = 32'h100;
    tick();
    chk("pre_rst_hit", 32'(pred_v_o), 1);
    chk("pre_rst_pc", pred_pc_o, 32'h700);
    idle_inputs();
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_pred_v", 32'(pred_v_o), 0);
    chk("mid_rst_pred_pc", pred_pc_o, 0);
    chk("mid_rst_succ", 32'(success_cnt_o), 0);
    chk("mid_rst_fail", 32'(failed_cnt_o), 0);
    model_reset();
    @(negedge clk) reset_n = 1'b1;
    if_v_i = 1; if_pc_i = 32'h100;
    tick();
    chk("post_rst_lookup", 32'(pred_v_o), 0);
    chk("post_rst_pc", pred_pc_o, 0);
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
